// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one data-memory port between core and loader
module mem_port_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_req_valid,
  output logic              c_req_ready,
  input  logic              c_req_we,
  input  logic [ADDR_W-1:0] c_req_addr,
  input  logic [DATA_W-1:0] c_req_wdata,
  output logic              c_rsp_valid,
  output logic [DATA_W-1:0] c_rsp_rdata,
  input  logic              l_req_valid,
  output logic              l_req_ready,
  input  logic              l_req_we,
  input  logic [ADDR_W-1:0] l_req_addr,
  input  logic [DATA_W-1:0] l_req_wdata,
  output logic              l_rsp_valid,
  output logic [DATA_W-1:0] l_rsp_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t        state;
  logic          rr_ptr;   // 0 = core next in line, 1 = loader next in line
  logic          owner;    // 0 = core, 1 = loader
  logic [CW-1:0] cnt;
  logic          grant_l;
  logic          accept_c;
  logic          accept_l;

  assign grant_l     = l_req_valid & (~c_req_valid | rr_ptr);
  assign c_req_ready = (state == IDLE) & ~rst & c_req_valid & ~grant_l;
  assign l_req_ready = (state == IDLE) & ~rst & grant_l;
  assign accept_c    = c_req_valid & c_req_ready;
  assign accept_l    = l_req_valid & l_req_ready;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      owner       <= 1'b0;
      cnt         <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      c_rsp_valid <= 1'b0;
      l_rsp_valid <= 1'b0;
      c_rsp_rdata <= '0;
      l_rsp_rdata <= '0;
    end else begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      c_rsp_valid <= 1'b0;
      l_rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_c | accept_l) begin
            owner     <= accept_l;
            rr_ptr    <= ~accept_l;
            mem_en    <= 1'b1;
            mem_we    <= accept_l ? l_req_we    : c_req_we;
            mem_addr  <= accept_l ? l_req_addr  : c_req_addr;
            mem_wdata <= accept_l ? l_req_wdata : c_req_wdata;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // mem_we still holds the latched request type during ACCESS
          if (mem_we) begin
            if (owner) begin
              l_rsp_valid <= 1'b1;
              l_rsp_rdata <= '0;
            end else begin
              c_rsp_valid <= 1'b1;
              c_rsp_rdata <= '0;
            end
            state <= RESP;
          end else begin
            cnt   <= CW'(READ_LAT - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (owner) begin
              l_rsp_valid <= 1'b1;
              l_rsp_rdata <= mem_rdata;
            end else begin
              c_rsp_valid <= 1'b1;
              c_rsp_rdata <= mem_rdata;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter (READ_LAT 1 and 3 instances)
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        c_req_valid, c_req_we, l_req_valid, l_req_we;
  logic [15:0] c_req_addr, c_req_wdata, l_req_addr, l_req_wdata;

  logic        a_c_req_ready, a_c_rsp_valid, a_l_req_ready, a_l_rsp_valid;
  logic [15:0] a_c_rsp_rdata, a_l_rsp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_mem_en, a_mem_we, a_busy;
  logic        b_c_req_ready, b_c_rsp_valid, b_l_req_ready, b_l_rsp_valid;
  logic [15:0] b_c_rsp_rdata, b_l_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_mem_en, b_mem_we, b_busy;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(1)) dut_a (
    .clk(clk), .rst(rst),
    .c_req_valid(c_req_valid), .c_req_ready(a_c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_rsp_valid(a_c_rsp_valid), .c_rsp_rdata(a_c_rsp_rdata),
    .l_req_valid(l_req_valid), .l_req_ready(a_l_req_ready), .l_req_we(l_req_we),
    .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata),
    .l_rsp_valid(a_l_rsp_valid), .l_rsp_rdata(a_l_rsp_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(3)) dut_b (
    .clk(clk), .rst(rst),
    .c_req_valid(c_req_valid), .c_req_ready(b_c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_rsp_valid(b_c_rsp_valid), .c_rsp_rdata(b_c_rsp_rdata),
    .l_req_valid(l_req_valid), .l_req_ready(b_l_req_ready), .l_req_we(l_req_we),
    .l_req_addr(l_req_addr), .l_req_wdata(l_req_wdata),
    .l_rsp_valid(b_l_rsp_valid), .l_rsp_rdata(b_l_rsp_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory models: read data exists only exactly READ_LAT cycles after the mem_en cycle
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic [15:0] pa0, pb0, pb1, pb2;
  assign a_mem_rdata = pa0;
  assign b_mem_rdata = pb2;

  always @(posedge clk) begin
    if (a_mem_en && a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
    pa0 <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr[7:0]] : 16'hDEAD;
    if (b_mem_en && b_mem_we) mem_b[b_mem_addr[7:0]] <= b_mem_wdata;
    pb0 <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[7:0]] : 16'hDEAD;
    pb1 <= pb0;
    pb2 <= pb1;
  end

  typedef struct {
    logic        cv, lv, cwe, lwe;
    logic [15:0] ca, cd, la, ld;
    logic        exp_l;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs [14];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    c_req_valid = 0; c_req_we = 0; c_req_addr = 0; c_req_wdata = 0;
    l_req_valid = 0; l_req_we = 0; l_req_addr = 0; l_req_wdata = 0;
  endtask

  logic [15:0] hold_c, hold_l;
  logic        o_we;
  logic [15:0] o_addr, o_wdata;

  initial begin
    vecs[0]  = '{1, 0, 0, 0, 16'h0010, 16'h0, 16'h0, 16'h0, 0, 16'hBEEF};
    vecs[1]  = '{0, 1, 0, 1, 16'h0, 16'h0, 16'h0020, 16'h1234, 1, 16'h0};
    for (int i = 0; i < 8; i++)
      vecs[2+i] = '{1, 1, 1, 1, 16'(16'h30 + i), 16'(16'hC000 + i),
                    16'(16'h40 + i), 16'(16'hA000 + i), i[0], 16'h0};
    vecs[10] = '{0, 1, 0, 0, 16'h0, 16'h0, 16'h0020, 16'h0, 1, 16'h1234};
    vecs[11] = '{1, 0, 0, 0, 16'h0030, 16'h0, 16'h0, 16'h0, 0, 16'hC000};
    vecs[12] = '{1, 1, 0, 0, 16'h0032, 16'h0, 16'h0043, 16'h0, 1, 16'hA003};
    vecs[13] = '{1, 1, 0, 0, 16'h0032, 16'h0, 16'h0043, 16'h0, 0, 16'hC002};

    mem_a[8'h10] = 16'hBEEF;
    mem_a[8'h50] = 16'h0000;
    mem_b[8'h50] = 16'h5A5A;

    // Reset with both requesters valid: nothing may be accepted
    rst = 1;
    idle_inputs();
    c_req_valid = 1; l_req_valid = 1; c_req_addr = 16'h0011; l_req_addr = 16'h0022;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_c_ready", a_c_req_ready, 0);
      chk("rst_l_ready", a_l_req_ready, 0);
      chk("rst_mem_en", a_mem_en, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_rsp", {a_c_rsp_valid, a_l_rsp_valid}, 0);
      chk("rst_rdata", a_c_rsp_rdata | a_l_rsp_rdata, 0);
    end
    rst = 0;
    idle_inputs();
    hold_c = 0;
    hold_l = 0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      c_req_valid = vecs[i].cv; c_req_we = vecs[i].cwe;
      c_req_addr  = vecs[i].ca; c_req_wdata = vecs[i].cd;
      l_req_valid = vecs[i].lv; l_req_we = vecs[i].lwe;
      l_req_addr  = vecs[i].la; l_req_wdata = vecs[i].ld;
      #1;
      chk($sformatf("v%0d_c_ready", i), a_c_req_ready, !vecs[i].exp_l);
      chk($sformatf("v%0d_l_ready", i), a_l_req_ready, vecs[i].exp_l);
      chk($sformatf("v%0d_busy_idle", i), a_busy, 0);
      o_we    = vecs[i].exp_l ? vecs[i].lwe : vecs[i].cwe;
      o_addr  = vecs[i].exp_l ? vecs[i].la  : vecs[i].ca;
      o_wdata = vecs[i].exp_l ? vecs[i].ld  : vecs[i].cd;

      @(negedge clk);
      idle_inputs();
      chk($sformatf("v%0d_mem_en", i), a_mem_en, 1);
      chk($sformatf("v%0d_mem_we", i), a_mem_we, o_we);
      chk($sformatf("v%0d_mem_addr", i), a_mem_addr, o_addr);
      chk($sformatf("v%0d_mem_wdata", i), a_mem_wdata, o_wdata);
      chk($sformatf("v%0d_busy", i), a_busy, 1);

      if (!o_we) begin
        @(negedge clk);
        chk($sformatf("v%0d_wait_rsp", i), {a_c_rsp_valid, a_l_rsp_valid}, 0);
        chk($sformatf("v%0d_wait_mem_en", i), a_mem_en, 0);
      end
      @(negedge clk);
      chk($sformatf("v%0d_mem_en_resp", i), a_mem_en, 0);
      if (vecs[i].exp_l) begin
        hold_l = vecs[i].exp_rd;
        chk($sformatf("v%0d_l_rsp_valid", i), a_l_rsp_valid, 1);
        chk($sformatf("v%0d_l_rsp_rdata", i), a_l_rsp_rdata, hold_l);
        chk($sformatf("v%0d_c_rsp_valid0", i), a_c_rsp_valid, 0);
        chk($sformatf("v%0d_c_rdata_hold", i), a_c_rsp_rdata, hold_c);
      end else begin
        hold_c = vecs[i].exp_rd;
        chk($sformatf("v%0d_c_rsp_valid", i), a_c_rsp_valid, 1);
        chk($sformatf("v%0d_c_rsp_rdata", i), a_c_rsp_rdata, hold_c);
        chk($sformatf("v%0d_l_rsp_valid0", i), a_l_rsp_valid, 0);
        chk($sformatf("v%0d_l_rdata_hold", i), a_l_rsp_rdata, hold_l);
      end
    end

    // Re-synchronise both instances, then READ_LAT=3 core read on dut_b
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst2_c_rdata", a_c_rsp_rdata, 0);
    chk("rst2_l_rdata", a_l_rsp_rdata, 0);
    chk("rst2_b_busy", b_busy, 0);
    c_req_valid = 1; c_req_addr = 16'h0050;
    #1;
    chk("lat3_c_ready", b_c_req_ready, 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      idle_inputs();
      chk($sformatf("lat3_mem_en_%0d", k), b_mem_en, (k == 1));
      chk($sformatf("lat3_busy_%0d", k), b_busy, (k <= 5));
      chk($sformatf("lat3_rsp_%0d", k), b_c_rsp_valid, (k == 5));
      if (k == 5) chk("lat3_rdata", b_c_rsp_rdata, 16'h5A5A);
    end

    // Reset in the middle of WAIT aborts the read and restores the pointer to C
    c_req_valid = 1; c_req_addr = 16'h0050;
    #1;
    chk("abort_c_ready", b_c_req_ready, 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 3) rst = 1;
      if (k == 4) begin
        rst = 0;
        chk("abort_busy", b_busy, 0);
        chk("abort_mem_en", b_mem_en, 0);
        chk("abort_rdata", b_c_rsp_rdata, 0);
      end
      if (k >= 4) chk($sformatf("abort_no_rsp_%0d", k), b_c_rsp_valid, 0);
    end
    c_req_valid = 1; c_req_we = 1; c_req_addr = 16'h0060;
    l_req_valid = 1; l_req_we = 1; l_req_addr = 16'h0061;
    #1;
    chk("post_rst_b_c_ready", b_c_req_ready, 1);
    chk("post_rst_b_l_ready", b_l_req_ready, 0);
    chk("post_rst_a_c_ready", a_c_req_ready, 1);
    chk("post_rst_a_l_ready", a_l_req_ready, 0);
    @(negedge clk);
    idle_inputs();
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
